// File: rtl/i2s_pkg.sv
// Shared widths, sample type, FSM state and slot-map helpers for the I2S master transmitter.
package i2s_pkg;

  localparam int DATA_W   = 24;
  localparam int SLOT_W   = 32;
  localparam int FRM_BITS = 64;
  localparam int BIT_W    = $clog2(FRM_BITS);

  localparam logic [BIT_W-1:0] BIT_RST  = BIT_W'(FRM_BITS - 2);
  localparam logic [BIT_W-1:0] BIT_XFER = BIT_W'(FRM_BITS - 2);

  typedef struct packed {
    logic signed [DATA_W-1:0] left;
    logic signed [DATA_W-1:0] right;
  } stereo_smpl_t;

  typedef enum logic {IDLE, RUN} tx_state_e;

  // WS is high one bit before the right slot until one bit before the next left slot.
  function automatic logic ws_for_bit(input logic [BIT_W-1:0] b);
    return (b >= BIT_W'(SLOT_W - 1)) && (b <= BIT_W'(FRM_BITS - 2));
  endfunction

  function automatic logic data_bit(input logic [BIT_W-1:0] b);
    return (b < BIT_W'(DATA_W)) ||
           ((b >= BIT_W'(SLOT_W)) && (b < BIT_W'(SLOT_W + DATA_W)));
  endfunction

endpackage

// File: rtl/i2s_sclk_gen.sv
// Bit-clock divider: down-counter with terminal-count toggle, held low while disabled.
module i2s_sclk_gen #(
  parameter int SCLK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic sclk_o,
  output logic sclk_fall_o,
  output logic sclk_rise_o
);

  localparam int CNT_W = $clog2(SCLK_DIV + 1);
  // The extra idle count makes the first rise land SCLK_DIV+1 clk after enable.
  localparam logic [CNT_W-1:0] LOAD_IDLE = CNT_W'(SCLK_DIV);
  localparam logic [CNT_W-1:0] LOAD_HALF = CNT_W'(SCLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             tc;

  assign tc = (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = LOAD_IDLE;
      sclk_d = 1'b0;
    end else if (tc) begin
      cnt_d  = LOAD_HALF;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= LOAD_IDLE;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o      = sclk_q;
  assign sclk_fall_o = en_i & tc & sclk_q;
  assign sclk_rise_o = en_i & tc & ~sclk_q;

endmodule

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: holding register, 48-bit shifter, Philips framing, underflow handling.
// Build option I2S_TX_UNDRFLW_MUTE_EN: underflow sends silence instead of repeating the last pair.
module i2s_master_tx
  import i2s_pkg::*;
#(
  parameter int SCLK_DIV = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] lft_in,
  input  logic [DATA_W-1:0] rght_in,
  input  logic              wrt,
  output logic              rdy,
  output logic              frm_strt,
  output logic              undrflw,
  output logic              I2S_sclk,
  output logic              I2S_ws,
  output logic              I2S_data
);

  tx_state_e             state_q, state_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  stereo_smpl_t          hold_q, hold_d;
  logic                  empty_q, empty_d;
  logic [2*DATA_W-1:0]   shift_q, shift_d;
  logic                  frm_q, frm_d;
  logic                  und_q, und_d;
  logic                  ws_q, ws_d;
  logic                  data_q, data_d;
`ifndef I2S_TX_UNDRFLW_MUTE_EN
  logic [2*DATA_W-1:0]   last_q, last_d;
`endif

  logic sclk_fall, sclk_rise, wr_ok, xfer;

  i2s_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (state_q == RUN),
    .sclk_o      (I2S_sclk),
    .sclk_fall_o (sclk_fall),
    .sclk_rise_o (sclk_rise)
  );

  assign wr_ok = wrt & empty_q;
  assign xfer  = sclk_fall & (bit_q == BIT_XFER);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    empty_d = empty_q;
    shift_d = shift_q;
    frm_d   = 1'b0;
    und_d   = 1'b0;
    ws_d    = ws_q;
    data_d  = data_q;
`ifndef I2S_TX_UNDRFLW_MUTE_EN
    last_d  = last_q;
`endif

    case (state_q)
      IDLE:    if (wr_ok) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (sclk_fall) begin
      bit_d = bit_q + BIT_W'(1);
      ws_d  = ws_for_bit(bit_d);
      if (data_bit(bit_d)) begin
        data_d  = shift_q[2*DATA_W-1];
        shift_d = {shift_q[2*DATA_W-2:0], 1'b0};
      end else begin
        data_d = 1'b0;
      end
      if (xfer) begin
        frm_d = 1'b1;
        if (!empty_q) begin
          shift_d = hold_q;
          empty_d = 1'b1;
`ifndef I2S_TX_UNDRFLW_MUTE_EN
          last_d  = hold_q;
`endif
        end else begin
          und_d = 1'b1;
`ifdef I2S_TX_UNDRFLW_MUTE_EN
          shift_d = '0;
`else
          shift_d = last_q;
`endif
        end
      end
    end

    // A write coinciding with an empty-register transfer is kept for the next frame.
    if (wr_ok) begin
      hold_d  = '{left: lft_in, right: rght_in};
      empty_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= BIT_RST;
      hold_q  <= '0;
      empty_q <= 1'b1;
      shift_q <= '0;
      frm_q   <= 1'b0;
      und_q   <= 1'b0;
      ws_q    <= 1'b1;
      data_q  <= 1'b0;
`ifndef I2S_TX_UNDRFLW_MUTE_EN
      last_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      empty_q <= empty_d;
      shift_q <= shift_d;
      frm_q   <= frm_d;
      und_q   <= und_d;
      ws_q    <= ws_d;
      data_q  <= data_d;
`ifndef I2S_TX_UNDRFLW_MUTE_EN
      last_q  <= last_d;
`endif
    end
  end

  // The bit clock may only run while the FSM is active.
  always_ff @(posedge clk) begin
    if (rst_n && sclk_rise) assert (state_q == RUN);
  end

  assign rdy      = empty_q;
  assign frm_strt = frm_q;
  assign undrflw  = und_q;
  assign I2S_ws   = ws_q;
  assign I2S_data = data_q;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Randomized bench for i2s_master_tx with a frame-level reference model and an I2S decoder.
module tb_i2s_master_tx;

  localparam int D     = 8;
  localparam int P     = 128 * D;
  localparam int FIRST = 2 * D + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrt = 1'b0;
  logic [23:0] lft_in = '0;
  logic [23:0] rght_in = '0;
  logic        rdy, frm_strt, undrflw, I2S_sclk, I2S_ws, I2S_data;

  i2s_master_tx #(.SCLK_DIV(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lft_in   (lft_in),
    .rght_in  (rght_in),
    .wrt      (wrt),
    .rdy      (rdy),
    .frm_strt (frm_strt),
    .undrflw  (undrflw),
    .I2S_sclk (I2S_sclk),
    .I2S_ws   (I2S_ws),
    .I2S_data (I2S_data)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] frame_of(input logic [47:0] p);
    return {p[47:24], 8'h00, p[23:0], 8'h00};
  endfunction

  // Reference model: transfers every P clk starting FIRST clk after the waking write.
  int unsigned cyc = 0;
  int unsigned t0 = 0;
  bit          m_run = 0, m_full = 0, e_frm = 0, e_und = 0, xf = 0;
  logic [47:0] m_hold = '0, m_last = '0;
  logic [63:0] exp_q[$];

  always @(posedge clk) begin
    cyc++;
    e_frm = 0;
    e_und = 0;
    if (!rst_n) begin
      m_run = 0; m_full = 0; m_hold = '0; m_last = '0;
      exp_q.delete();
    end else begin
      xf = m_run && (((cyc - t0) % P) == FIRST);
      if (xf) begin
        e_frm = 1;
        if (m_full) begin
          exp_q.push_back(frame_of(m_hold));
          m_last = m_hold;
          m_full = 0;
        end else begin
          e_und = 1;
`ifdef I2S_TX_UNDRFLW_MUTE_EN
          exp_q.push_back(64'h0);
`else
          exp_q.push_back(frame_of(m_last));
`endif
        end
      end
      if (wrt && !m_full) begin
        m_hold = {lft_in, rght_in};
        m_full = 1;
        if (!m_run) begin
          m_run = 1;
          t0 = cyc;
        end
      end
    end
  end

  function automatic bit xfer_next();
    return m_run && (((cyc + 1 - t0) % P) == FIRST);
  endfunction

  // Output checks and receive-side decoder, sampled on the falling clk edge.
  bit          prev_sclk = 0, prev_ws = 1, have = 0, cnt_und = 0;
  int          bcnt = 0, rx_cnt = 0, und_seen = 0;
  logic [63:0] fr = '0, frm = '0, last_rx = '0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("rdy", rdy, !m_full);
      chk("frm_strt", frm_strt, e_frm);
      chk("undrflw", undrflw, e_und);
      if (cnt_und && undrflw) und_seen++;
      if (!m_run) begin
        chk("idle_sclk", I2S_sclk, 0);
        chk("idle_ws", I2S_ws, 1);
        chk("idle_data", I2S_data, 0);
        prev_sclk = 0; prev_ws = 1; have = 0;
      end else begin
        if (I2S_sclk && !prev_sclk) begin
          if (!I2S_ws && prev_ws) begin
            chk("b63_data", I2S_data, 0);
            bcnt = 0; have = 1; fr = '0;
          end else if (have) begin
            bcnt++;
            if (bcnt > 63) begin
              chk("frame_len", bcnt, 63);
              have = 0;
            end else begin
              fr = {fr[62:0], I2S_data};
              chk("ws_slot", I2S_ws, (bcnt >= 32));
              if (bcnt == 63) begin
                frm = {fr[62:0], 1'b0};
                chk("exp_avail", exp_q.size(), 1);
                if (exp_q.size() > 0) chk("frame", frm, exp_q.pop_front());
                last_rx = frm;
                rx_cnt++;
              end
            end
          end
          prev_ws = I2S_ws;
        end
        prev_sclk = I2S_sclk;
      end
    end
  end

  task automatic do_wrt(input logic [23:0] l, input logic [23:0] r);
    wrt = 1'b1; lft_in = l; rght_in = r;
    @(negedge clk);
    wrt = 1'b0;
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!rdy && n < 3 * P) begin @(negedge clk); n++; end
    if (n >= 3 * P) chk("rdy_timeout", rdy, 1);
  endtask

  task automatic wait_frames(input int k);
    int target = rx_cnt + k;
    int n = 0;
    while (rx_cnt < target && n < (k + 2) * P) begin @(negedge clk); n++; end
    if (rx_cnt < target) chk("rx_timeout", rx_cnt, target);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // directed pair, extreme values
    do_wrt(24'h800001, 24'h7FFFFE);
    wait_frames(1);
    chk("directed_frame", last_rx, 64'h80000100_7FFFFE00);

    // back-to-back ramp (n, -n)
    for (int n = 1; n <= 16; n++) begin
      wait_rdy();
      do_wrt(24'(n), 24'(-n));
      cnt_und = 1;
    end
    wait_frames(2);
    cnt_und = 0;
    chk("ramp_undrflw", und_seen, 0);

    // starve the transmitter for a few frames
    wait_frames(3);

    // write while full is dropped
    wait_rdy();
    do_wrt(24'($urandom), 24'($urandom));
    do_wrt(24'h123456, 24'h123456);
    wait_frames(2);

    // write landing exactly on an empty-register transfer
    begin
      int n = 0;
      while (!(xfer_next() && !m_full) && n < 3 * P) begin @(negedge clk); n++; end
      chk("xfer_align", (xfer_next() && !m_full), 1);
      do_wrt(24'($urandom), 24'($urandom));
      wait_frames(3);
    end

    // randomized producer pacing
    for (int i = 0; i < 12; i++) begin
      wait_rdy();
      repeat ($urandom_range(0, P)) @(negedge clk);
      do_wrt(24'($urandom), 24'($urandom));
      if ($urandom_range(0, 2) == 0) do_wrt(24'($urandom), 24'($urandom));
    end
    wait_frames(2);

    // reset in the middle of the right slot (b=40)
    begin
      int n = 0;
      while (!e_frm && n < 2 * P) begin @(negedge clk); n++; end
      repeat (41 * 2 * D + 3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_sclk", I2S_sclk, 0);
      chk("rst_ws", I2S_ws, 1);
      chk("rst_rdy", rdy, 1);
      repeat (300) @(negedge clk);
      do_wrt(24'($urandom), 24'($urandom));
      wait_rdy();
      do_wrt(24'($urandom), 24'($urandom));
      wait_frames(3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
